// File: rtl/train_sample_feeder_if.sv
// rtl/train_sample_feeder_if.sv - sample-load, run-control and replay signals of the training sample feeder
interface train_sample_feeder_if #(
    parameter int DEPTH = 8,
    parameter int X_W   = 4,
    parameter int Y_W   = 4,
    parameter int EP_W  = 8
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;

    logic            wr_en_i;
    logic [X_W-1:0]  wr_x_i;
    logic [Y_W-1:0]  wr_y_i;
    logic            clear_i;
    logic            start_i;
    logic [EP_W-1:0] epochs_i;
    logic            iter_done_i;

    logic [X_W-1:0]  x_o;
    logic [Y_W-1:0]  y_o;
    logic            init_o;
    logic            busy_o;
    logic            done_o;
    logic [CW-1:0]   count_o;
    logic            full_o;
    logic            empty_o;
    logic            overflow_o;
    logic [IW-1:0]   idx_o;
    logic [EP_W-1:0] epoch_o;

    modport master (
        output wr_en_i, wr_x_i, wr_y_i, clear_i, start_i, epochs_i, iter_done_i,
        input  x_o, y_o, init_o, busy_o, done_o, count_o, full_o, empty_o,
               overflow_o, idx_o, epoch_o
    );

    modport slave (
        input  wr_en_i, wr_x_i, wr_y_i, clear_i, start_i, epochs_i, iter_done_i,
        output x_o, y_o, init_o, busy_o, done_o, count_o, full_o, empty_o,
               overflow_o, idx_o, epoch_o
    );
endinterface

// File: rtl/train_sample_feeder.sv
// rtl/train_sample_feeder.sv - buffers training samples and replays them for a programmed number of epochs
module train_sample_feeder #(
    parameter int DEPTH = 8,
    parameter int X_W   = 4,
    parameter int Y_W   = 4,
    parameter int EP_W  = 8
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    train_sample_feeder_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int SW = X_W + Y_W;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t          r_state;
    state_t          w_next;

    logic [SW-1:0]   r_mem [DEPTH];
    logic [CW-1:0]   r_count;
    logic            r_ovf;
    logic [IW-1:0]   r_idx;
    logic [EP_W-1:0] r_epoch;
    logic [EP_W-1:0] r_epochs;
    logic [X_W-1:0]  r_x;
    logic [Y_W-1:0]  r_y;

    logic            w_full;
    logic            w_more;
    logic            w_last_epoch;
    logic [IW-1:0]   w_next_idx;
    logic            w_clear;
    logic            w_abort;
    logic            w_start_run;
    logic            w_write;
    logic            w_drop;
    logic            w_step;
    logic            w_wrap;

    assign w_full       = (r_count == CW'(DEPTH));
    assign w_more       = (({1'b0, r_idx} + CW'(1)) < r_count);
    assign w_last_epoch = (({1'b0, r_epoch} + (EP_W+1)'(1)) == {1'b0, r_epochs});
    assign w_next_idx   = r_idx + IW'(1);

    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        w_abort     = 1'b0;
        w_start_run = 1'b0;
        w_write     = 1'b0;
        w_drop      = 1'b0;
        w_step      = 1'b0;
        w_wrap      = 1'b0;
        case (r_state)
            S_IDLE, S_DONE: begin
                // clear beats start beats write; a write alongside start is silently lost
                if (bus.clear_i) begin
                    w_clear = 1'b1;
                    w_next  = S_IDLE;
                end else if (bus.start_i) begin
                    if (r_count == '0 || bus.epochs_i == '0) begin
                        w_next = S_DONE;
                    end else begin
                        w_start_run = 1'b1;
                        w_next      = S_ISSUE;
                    end
                end else if (bus.wr_en_i) begin
                    w_write = !w_full;
                    w_drop  = w_full;
                end
            end
            S_ISSUE: begin
                if (bus.clear_i) begin
                    w_clear = 1'b1;
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (bus.clear_i) begin
                    w_clear = 1'b1;
                    w_abort = 1'b1;
                    w_next  = S_IDLE;
                end else if (bus.iter_done_i) begin
                    if (w_more) begin
                        w_step = 1'b1;
                        w_next = S_ISSUE;
                    end else begin
                        w_wrap = 1'b1;
                        w_next = w_last_epoch ? S_DONE : S_ISSUE;
                    end
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // sample storage is deliberately unreset; r_count alone marks which slots are valid
    always_ff @(posedge clk_i) begin
        if (!rst_i && w_write) r_mem[r_count[IW-1:0]] <= {bus.wr_x_i, bus.wr_y_i};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_idx    <= '0;
            r_epoch  <= '0;
            r_epochs <= '0;
            r_x      <= '0;
            r_y      <= '0;
        end else begin
            if (w_clear) begin
                r_count <= '0;
                r_ovf   <= 1'b0;
            end
            if (w_write) r_count <= r_count + CW'(1);
            if (w_drop)  r_ovf   <= 1'b1;
            if (w_abort) begin
                r_idx   <= '0;
                r_epoch <= '0;
                r_x     <= '0;
                r_y     <= '0;
            end
            if (w_start_run) begin
                r_epochs     <= bus.epochs_i;
                r_idx        <= '0;
                r_epoch      <= '0;
                {r_x, r_y}   <= r_mem[0];
            end
            if (w_step) begin
                r_idx        <= w_next_idx;
                {r_x, r_y}   <= r_mem[w_next_idx];
            end
            if (w_wrap) begin
                r_idx   <= '0;
                r_epoch <= r_epoch + EP_W'(1);
                // on the final wrap the last sample stays on the bus
                if (!w_last_epoch) {r_x, r_y} <= r_mem[0];
            end
        end
    end

    assign bus.x_o        = r_x;
    assign bus.y_o        = r_y;
    assign bus.init_o     = (r_state == S_ISSUE);
    assign bus.busy_o     = (r_state == S_ISSUE) || (r_state == S_WAIT);
    assign bus.done_o     = (r_state == S_DONE);
    assign bus.count_o    = r_count;
    assign bus.full_o     = w_full;
    assign bus.empty_o    = (r_count == '0);
    assign bus.overflow_o = r_ovf;
    assign bus.idx_o      = r_idx;
    assign bus.epoch_o    = r_epoch;
endmodule

// File: tb/tb_train_sample_feeder.sv
// tb/tb_train_sample_feeder.sv - randomized self-checking bench for train_sample_feeder against a queue-based replay model
module tb_train_sample_feeder;
    localparam int DEPTH = 8;
    localparam int X_W   = 4;
    localparam int Y_W   = 4;
    localparam int EP_W  = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    train_sample_feeder_if #(.DEPTH(DEPTH), .X_W(X_W), .Y_W(Y_W), .EP_W(EP_W)) bus ();

    train_sample_feeder #(.DEPTH(DEPTH), .X_W(X_W), .Y_W(Y_W), .EP_W(EP_W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] mq[$];
    logic       movf = 1'b0;

    logic [7:0] cap[$];
    int         cap_cyc[$];
    int         cyc        = 0;
    bit         auto_mode  = 1'b0;
    int         resp_delay = 1;
    int         cd         = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // records every init pulse and, in auto mode, answers it with iter_done after resp_delay cycles
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (auto_mode) begin
                bus.iter_done_i = 1'b0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) bus.iter_done_i = 1'b1;
                end
            end
            if (bus.init_o) begin
                cap.push_back({bus.x_o, bus.y_o});
                cap_cyc.push_back(cyc);
                if (auto_mode) cd = resp_delay;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic wr(input logic [3:0] x, input logic [3:0] y);
        bus.wr_en_i = 1'b1;
        bus.wr_x_i  = x;
        bus.wr_y_i  = y;
        tick();
        bus.wr_en_i = 1'b0;
        if (mq.size() < DEPTH) mq.push_back({x, y});
        else movf = 1'b1;
    endtask

    task automatic clr();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        mq.delete();
        movf = 1'b0;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count"}, 32'(bus.count_o), 32'(mq.size()));
        check({tag, "_full"},  32'(bus.full_o), 32'(mq.size() == DEPTH));
        check({tag, "_empty"}, 32'(bus.empty_o), 32'(mq.size() == 0));
        check({tag, "_ovf"},   32'(bus.overflow_o), 32'(movf));
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!bus.done_o && n < budget) begin
            tick();
            n++;
        end
        check({tag, "_done_in_time"}, 32'(bus.done_o), 32'd1);
    endtask

    // expected replay: every stored sample in order, repeated once per epoch
    task automatic run(input string tag, input int ep, input int delay);
        int n;
        cap.delete();
        cap_cyc.delete();
        cd          = 0;
        resp_delay  = delay;
        auto_mode   = 1'b1;
        bus.epochs_i = EP_W'(ep);
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        check({tag, "_first_init"}, 32'(bus.init_o), 32'd1);
        check({tag, "_first_busy"}, 32'(bus.busy_o), 32'd1);
        check({tag, "_first_xy"}, 32'({bus.x_o, bus.y_o}), 32'(mq[0]));
        wait_done(tag, 1000);
        n = mq.size();
        check({tag, "_n_init"}, 32'(cap.size()), 32'(n * ep));
        for (int e = 0; e < ep; e++) begin
            for (int i = 0; i < n; i++) begin
                int k;
                k = e * n + i;
                check({tag, "_replay"}, (k < cap.size()) ? 32'(cap[k]) : 32'hFFFF_FFFF, 32'(mq[i]));
            end
        end
        check({tag, "_epoch"}, 32'(bus.epoch_o), 32'(ep));
        check({tag, "_busy_end"}, 32'(bus.busy_o), 32'd0);
        check({tag, "_idx_end"}, 32'(bus.idx_o), 32'd0);
        check({tag, "_xy_last"}, 32'({bus.x_o, bus.y_o}), 32'(mq[n-1]));
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_init"},  32'(bus.init_o), 32'd0);
        check({tag, "_busy"},  32'(bus.busy_o), 32'd0);
        check({tag, "_done"},  32'(bus.done_o), 32'd0);
        check({tag, "_x"},     32'(bus.x_o), 32'd0);
        check({tag, "_y"},     32'(bus.y_o), 32'd0);
        check({tag, "_idx"},   32'(bus.idx_o), 32'd0);
        check({tag, "_epoch"}, 32'(bus.epoch_o), 32'd0);
        check_status(tag);
    endtask

    initial begin
        int n, ep, d;
        bus.wr_en_i     = 1'b0;
        bus.wr_x_i      = '0;
        bus.wr_y_i      = '0;
        bus.clear_i     = 1'b0;
        bus.start_i     = 1'b0;
        bus.epochs_i    = '0;
        bus.iter_done_i = 1'b0;
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        check_reset_values("reset");

        wr(4'd1, 4'd9);
        wr(4'd2, 4'd8);
        wr(4'd3, 4'd7);
        check_status("load3");
        run("basic", 2, 3);

        clr();
        for (int i = 0; i < DEPTH + 1; i++) wr(4'($urandom), 4'($urandom));
        check_status("overfill");
        run("overfill_run", 1, 1);
        clr();
        check_status("after_clear");

        cap.delete();
        bus.epochs_i = 8'd3;
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        check("empty_start_done", 32'(bus.done_o), 32'd1);
        check("empty_start_init", 32'(bus.init_o), 32'd0);
        wr(4'd5, 4'd6);
        wr(4'd7, 4'd8);
        check_status("write_in_done");
        bus.epochs_i = 8'd0;
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        check("zero_ep_done", 32'(bus.done_o), 32'd1);
        for (int i = 0; i < 4; i++) tick();
        check("no_init_count", 32'(cap.size()), 32'd0);

        clr();
        wr(4'd10, 4'd1);
        wr(4'd11, 4'd2);
        auto_mode = 1'b0;
        cap.delete();
        cap_cyc.delete();
        bus.iter_done_i = 1'b1;
        bus.epochs_i    = 8'd1;
        bus.start_i     = 1'b1;
        tick();
        bus.start_i     = 1'b0;
        wait_done("hold", 40);
        bus.iter_done_i = 1'b0;
        check("hold_n_init", 32'(cap.size()), 32'd2);
        check("hold_spacing", (cap_cyc.size() == 2) ? 32'(cap_cyc[1] - cap_cyc[0]) : 32'hFFFF_FFFF, 32'd2);
        check("hold_s1", (cap.size() > 1) ? 32'(cap[1]) : 32'hFFFF_FFFF, 32'(mq[1]));

        clr();
        for (int i = 0; i < 3; i++) wr(4'($urandom), 4'($urandom));
        cap.delete();
        cd = 0;
        resp_delay = 4;
        auto_mode  = 1'b1;
        bus.epochs_i = 8'd2;
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        tick();
        bus.wr_en_i  = 1'b1;
        bus.wr_x_i   = 4'($urandom);
        bus.wr_y_i   = 4'($urandom);
        bus.start_i  = 1'b1;
        bus.epochs_i = 8'd5;
        tick();
        bus.wr_en_i  = 1'b0;
        bus.start_i  = 1'b0;
        check_status("write_in_run");
        n = 0;
        while (cap.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        check("abort_second_init", (cap.size() > 1) ? 32'(cap[1]) : 32'hFFFF_FFFF, 32'(mq[1]));
        tick();
        bus.clear_i = 1'b1;
        tick();
        bus.clear_i = 1'b0;
        mq.delete();
        movf = 1'b0;
        check_reset_values("abort");
        for (int i = 0; i < 8; i++) tick();
        check("abort_no_more_init", 32'(cap.size()), 32'd2);

        for (int i = 0; i < 3; i++) wr(4'($urandom), 4'($urandom));
        cap.delete();
        cd = 0;
        resp_delay = 2;
        bus.epochs_i = 8'd2;
        bus.start_i  = 1'b1;
        tick();
        bus.start_i  = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        cap.delete();
        mq.delete();
        movf = 1'b0;
        check_reset_values("midrun_reset");
        for (int i = 0; i < 6; i++) tick();
        check("reset_no_more_init", 32'(cap.size()), 32'd0);
        wr(4'd1, 4'd9);
        wr(4'd2, 4'd8);
        wr(4'd3, 4'd7);
        run("after_reset", 2, 3);

        for (int r = 0; r < 5; r++) begin
            clr();
            n  = $urandom_range(1, DEPTH);
            ep = $urandom_range(1, 3);
            d  = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) wr(4'($urandom), 4'($urandom));
            check_status("rand_load");
            run("rand", ep, d);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
